// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush and an optional 2-entry skid buffer.
// Low CTRL_W bits of the bundle are forced to zero whenever the stage presents a bubble.
module pipe_stage_skid #(
  parameter int unsigned W      = 109,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             cnt_clr
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     main_q, main_d;
  logic [W-1:0]     skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign occ       = state_q;
  assign stall_cnt = stall_cnt_q;

  // With the skid buffer, in_ready depends only on registered state and flush.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = (state_q != StSkid) && !flush;
  end else begin : g_pass_ready
    assign in_ready = ((state_q == StEmpty) || out_ready) && !flush;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    out_data = main_q;
    if (!out_valid) begin
      out_data[CTRL_W-1:0] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StFull;
          main_d  = in_data;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && (SKID != 0)) begin
          state_d = StSkid;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_fire) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid; a skid and a no-skid instance share stimulus
// and are compared every cycle against queue-based reference models.
module tb_pipe_stage_skid;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, cnt_clr;
  logic [W-1:0]  in_data;

  logic          a_in_ready, a_out_valid;
  logic [W-1:0]  a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_cnt;

  logic          b_in_ready, b_out_valid;
  logic [W-1:0]  b_out_data;
  logic [1:0]    b_occ;
  logic [3:0]    b_cnt;

  pipe_stage_skid #(.W(W), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occ(a_occ), .stall_cnt(a_cnt), .cnt_clr(cnt_clr)
  );

  pipe_stage_skid #(.W(W), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut_pass (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occ(b_occ), .stall_cnt(b_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int           cnt_a = 0;
  int           cnt_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic ra, rb;
    if (rst) return;
    ra = (qa.size() < 2) && !flush;
    rb = ((qa.size() >= 0) && (qb.size() == 0 || out_ready)) && !flush;
    check("a_in_ready", 64'(a_in_ready), 64'(ra));
    check("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
    if (qa.size() != 0) check("a_out_data", 64'(a_out_data), 64'(qa[0]));
    else check("a_bubble_ctrl", 64'(a_out_data[CW-1:0]), 64'(0));
    check("a_occ", 64'(a_occ), 64'(qa.size()));
    check("a_stall_cnt", 64'(a_cnt), 64'(cnt_a));
    check("b_in_ready", 64'(b_in_ready), 64'(rb));
    check("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
    if (qb.size() != 0) check("b_out_data", 64'(b_out_data), 64'(qb[0]));
    else check("b_bubble_ctrl", 64'(b_out_data[CW-1:0]), 64'(0));
    check("b_occ", 64'(b_occ), 64'(qb.size()));
    check("b_stall_cnt", 64'(b_cnt), 64'(cnt_b));
  endtask

  // Reference models: a FIFO of capacity 2 (skid) or 1 (pass-through), updated per clock edge.
  task automatic update_models();
    logic va, vb, ra, rb;
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a = 0;
      cnt_b = 0;
      return;
    end
    va = qa.size() != 0;
    vb = qb.size() != 0;
    ra = (qa.size() < 2) && !flush;
    rb = (!vb || out_ready) && !flush;
    if (cnt_clr) cnt_a = 0;
    else if (va && !out_ready && cnt_a < 65535) cnt_a++;
    if (cnt_clr) cnt_b = 0;
    else if (vb && !out_ready && cnt_b < 15) cnt_b++;
    if (va && out_ready) void'(qa.pop_front());
    if (vb && out_ready) void'(qb.pop_front());
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (in_valid && ra) qa.push_back(in_data);
      if (in_valid && rb) qb.push_back(in_data);
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    update_models();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;

    // Reset with in_valid held high
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_out_data", 64'(a_out_data), 64'(0));
    check("rst_occ", 64'(a_occ), 64'(0));
    check("rst_stall_cnt", 64'(a_cnt), 64'(0));
    check("rst_in_ready", 64'(a_in_ready), 64'(1));

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
      check("stream_data", 64'(a_out_data), 64'(i));
      check("stream_occ", 64'(a_occ), 64'(1));
    end
    in_valid = 1'b0;
    step();

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_0011;
    step();
    in_data = 32'h5A5A_0016;
    step();
    in_valid = 1'b0;
    step();
    check("bp_occ", 64'(a_occ), 64'(2));
    check("bp_in_ready", 64'(a_in_ready), 64'(0));
    check("bp_stall_cnt", 64'(a_cnt), 64'(2));
    out_ready = 1'b1;
    step();
    check("bp_second", 64'(a_out_data), 64'h5A5A_0016);
    check("bp_occ1", 64'(a_occ), 64'(1));
    step();
    check("bp_occ0", 64'(a_occ), 64'(0));

    // Flush while full with a new bundle offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1111_001F;
    step();
    in_data = 32'h2222_0013;
    step();
    in_data = 32'h3333_0017; flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(a_in_ready), 64'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occ", 64'(a_occ), 64'(0));
    check("flush_out_valid", 64'(a_out_valid), 64'(0));
    check("flush_ctrl", 64'(a_out_data[CW-1:0]), 64'(0));
    out_ready = 1'b1;
    step();
    check("flush_c_dropped", 64'(a_out_valid), 64'(0));

    // Saturating 4-bit counter on the pass-through instance
    out_ready = 1'b0; cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0001;
    step();
    cnt_clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("cnt_saturate", 64'(b_cnt), 64'(15));
    cnt_clr = 1'b1;
    step();
    check("cnt_clear", 64'(b_cnt), 64'(0));
    cnt_clr = 1'b0; out_ready = 1'b1;
    step();
    step();

    // Randomised traffic against both models
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom % 2) == 0;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom % 64) == 0;
      cnt_clr   = ($urandom % 128) == 0;
      in_data   = $urandom;
      step();
      check("rand_b_occ_le1", 64'(b_occ <= 2'd1), 64'(1));
    end
    flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
